// File: rtl/wb_regs_pkg.sv
// rtl/wb_regs_pkg.sv - shared types and helpers for the Wishbone register slave
// Contents:
//   state_t    : slave FSM states (idle, wait-state insertion, response)
//   WAIT_CNT_W : width of the wait-state counter (covers 0..15 wait states)
//   idx_width  : register index width, never narrower than one bit
package wb_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 4;

    function automatic int idx_width(input int n_regs);
        return (n_regs > 1) ? $clog2(n_regs) : 1;
    endfunction

endpackage

// File: rtl/wb_regs_slave_if.sv
// rtl/wb_regs_slave_if.sv - Wishbone classic bus bundle with master/slave views
// Signals:
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i : master -> slave
//   wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o                     : slave -> master
interface wb_regs_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_regs_bank.sv
// rtl/wb_regs_bank.sv - register array with byte-enable write port and read mux
// Ports:
//   clk, rst  : clock, async active-high reset (clears all registers)
//   wr_en     : commit a write to register idx this edge
//   idx       : register index shared by the write port and read mux
//   wr_sel    : byte enables for the write
//   wr_data   : write data
//   rd_data   : combinational contents of register idx
//   regs      : flattened register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse  : one-cycle flag per register, set the cycle after its write edge
module wb_regs_bank #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8,
    parameter int N_REGS = 8,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         idx,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [N_REGS*DATA_W-1:0] regs,
    output logic [N_REGS-1:0]        wr_pulse
);

    logic [DATA_W-1:0] mem [N_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_REGS; k++) begin
                mem[k] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_en) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (wr_sel[b]) begin
                        mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
                // Pulse fires even with no byte enabled: the write still happened.
                wr_pulse[idx] <= 1'b1;
            end
        end
    end

    assign rd_data = mem[idx];

    for (genvar k = 0; k < N_REGS; k++) begin : g_flat
        assign regs[k*DATA_W +: DATA_W] = mem[k];
    end

endmodule

// File: rtl/wb_regs_slave.sv
// rtl/wb_regs_slave.sv - Wishbone classic slave exposing a bank of N_REGS registers
// Optional feature macro: WB_REGS_ERR_EN (out-of-range accesses end with err instead of ack)
// Ports:
//   clk        : clock
//   rst        : async reset, active-high
//   bus        : Wishbone slave view (cyc/stb/we/adr/sel/dat_i in, dat_o/ack/err/rty out)
//   regs_o     : register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse_o : bit k high for the one cycle after reg k is written
module wb_regs_slave
    import wb_regs_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = DATA_W / 8,
    parameter int N_REGS      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_regs_slave_if.slave           bus,
    output logic [N_REGS*DATA_W-1:0] regs_o,
    output logic [N_REGS-1:0]        wr_pulse_o
);

    localparam int ADDR_LSB = $clog2(SEL_W);
    localparam int IDX_W    = idx_width(N_REGS);

`ifdef WB_REGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Address bits that must be zero: the sub-word offset and everything above the index.
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((64'd1 << ADDR_LSB) - 64'd1);
    localparam logic [ADDR_W-1:0] HIGH_MASK = ~ADDR_W'((64'd1 << (ADDR_LSB + IDX_W)) - 64'd1);
    localparam logic [ADDR_W-1:0] BAD_MASK  = LOW_MASK | HIGH_MASK;

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_W-1:0]       dat_q;

    logic                    req;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic                    enter_resp;
    logic                    commit;
    logic [DATA_W-1:0]       rd_data;

    assign req      = bus.wb_cyc_i & bus.wb_stb_i;
    assign idx      = bus.wb_adr_i[ADDR_LSB +: IDX_W];
    assign in_range = ~|(bus.wb_adr_i & BAD_MASK);

    // The edge that moves the FSM into RESP is where the request is committed,
    // so address/data are taken at that edge rather than when first seen.
    assign enter_resp = req &&
        (((state == ST_IDLE) && (WAIT_STATES == 0)) ||
         ((state == ST_WAIT) && (wait_cnt == LAST_WAIT)));
    assign commit = enter_resp & bus.wb_we_i & in_range;

    wb_regs_bank #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .N_REGS (N_REGS),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (commit),
        .idx      (idx),
        .wr_sel   (bus.wb_sel_i),
        .wr_data  (bus.wb_dat_i),
        .rd_data  (rd_data),
        .regs     (regs_o),
        .wr_pulse (wr_pulse_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            // Response outputs are only ever non-zero for the single RESP cycle.
            ack_q <= enter_resp && (in_range || !ERR_EN);
            err_q <= enter_resp && ERR_EN && !in_range;
            dat_q <= (enter_resp && !bus.wb_we_i && in_range) ? rd_data : '0;

            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (req) begin
                        state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= ST_RESP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_dat_o = dat_q;
    assign bus.wb_rty_o = 1'b0;

endmodule
